// File: rtl/serial_rx_sequencer_if.sv
// Bundle between the serial receive sequencer and the address/data shift registers and port demux.
// master = sequencer side, slave = line driver / datapath side.
interface serial_rx_sequencer_if #(
  parameter int ADDR_W = 2
) ();
  logic                   ser_in;
  logic                   addr_sh_en;
  logic                   data_sh_en;
  logic [ADDR_W-1:0]      port_sel;
  logic [(2**ADDR_W)-1:0] port_valid;
  logic                   done;
  logic                   busy;
  logic                   frame_err;

  modport master (
    input  ser_in,
    output addr_sh_en, data_sh_en, port_sel, port_valid, done, busy, frame_err
  );

  modport slave (
    output ser_in,
    input  addr_sh_en, data_sh_en, port_sel, port_valid, done, busy, frame_err
  );
endinterface

// File: rtl/serial_rx_sequencer.sv
// Serial frame receive controller: start detect, address capture, data shift enables, stop check.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_rx_sequencer #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_rx_sequencer_if.master  bus
);
  localparam int NPORTS = 2**ADDR_W;
  localparam int MAXW   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W  = $clog2(MAXW) + 1;

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAR, STOP, RESYNC} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, STOP, RESYNC} state_t;
`endif

  state_t              state;
  logic [CNT_W-1:0]    bitCnt;
  logic [ADDR_W-1:0]   portSel;
  logic [NPORTS-1:0]   portValid;
  logic                doneP;
  logic                frameErr;
  logic [ADDR_W:0]     selShift;
  logic [NPORTS-1:0]   selOneHot;
  logic                stopBad;
`ifdef SERIAL_RX_PARITY_EN
  logic                parAcc;
  logic                perr;
`endif

  assign selShift = {portSel, bus.ser_in};

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_onehot
      assign selOneHot[gi] = (portSel == ADDR_W'(gi));
    end
  endgenerate

  // A frame is rejected on a low stop bit or a latched parity mismatch.
`ifdef SERIAL_RX_PARITY_EN
  assign stopBad = !bus.ser_in || perr;
`else
  assign stopBad = !bus.ser_in;
`endif

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bitCnt    <= '0;
      portSel   <= '0;
      portValid <= '0;
      doneP     <= 1'b0;
      frameErr  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parAcc    <= 1'b0;
      perr      <= 1'b0;
`endif
    end else begin
      doneP     <= 1'b0;
      frameErr  <= 1'b0;
      portValid <= '0;
      case (state)
        IDLE: begin
          bitCnt <= '0;
          if (!bus.ser_in) begin
            state <= ADDR;
`ifdef SERIAL_RX_PARITY_EN
            parAcc <= 1'b0;
            perr   <= 1'b0;
`endif
          end
        end
        ADDR: begin
          portSel <= selShift[ADDR_W-1:0];
`ifdef SERIAL_RX_PARITY_EN
          parAcc <= parAcc ^ bus.ser_in;
`endif
          if (bitCnt == CNT_W'(ADDR_W - 1)) begin
            state  <= DATA;
            bitCnt <= '0;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        DATA: begin
`ifdef SERIAL_RX_PARITY_EN
          parAcc <= parAcc ^ bus.ser_in;
`endif
          if (bitCnt == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
            state <= PAR;
`else
            state <= STOP;
`endif
            bitCnt <= '0;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PAR: begin
          perr  <= bus.ser_in ^ parAcc;
          state <= STOP;
        end
`endif
        STOP: begin
          bitCnt <= '0;
          if (!stopBad) begin
            doneP     <= 1'b1;
            portValid <= selOneHot;
            state     <= IDLE;
          end else begin
            frameErr <= 1'b1;
            // A low stop bit may be a stuck line; wait for it to return high.
            state    <= bus.ser_in ? IDLE : RESYNC;
          end
        end
        RESYNC: begin
          bitCnt <= '0;
          if (bus.ser_in) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          bitCnt <= '0;
        end
      endcase
    end
  end

  assign bus.addr_sh_en = (state == ADDR);
  assign bus.data_sh_en = (state == DATA);
  assign bus.busy       = (state != IDLE);
  assign bus.port_sel   = portSel;
  assign bus.port_valid = portValid;
  assign bus.done       = doneP;
  assign bus.frame_err  = frameErr;
endmodule

// File: tb/tb_serial_rx_sequencer.sv
// Bench for serial_rx_sequencer: frame-level reference model builds a per-cycle vector table
// (directed frames plus random frames), then a loop applies and checks it; reset is hand-sequenced.
module tb_serial_rx_sequencer;
  localparam int A  = 2;
  localparam int D  = 8;
  localparam int NP = 1 << A;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = 1 + A + D + P + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_rx_sequencer_if #(.ADDR_W(A)) bus ();
  serial_rx_sequencer #(.ADDR_W(A), .DATA_W(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // flags = {addr_sh_en, data_sh_en, busy, done, frame_err}
  typedef struct {
    logic          ser;
    logic [4:0]    flags;
    logic [NP-1:0] pv;
    logic          chkSel;
    logic [A-1:0]  sel;
  } vec_t;

  vec_t         vecQ[$];
  logic [A-1:0] curSel;
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;

  function automatic logic [4:0] gotFlags();
    return {bus.addr_sh_en, bus.data_sh_en, bus.busy, bus.done, bus.frame_err};
  endfunction

  function automatic void pushVec(logic ser, logic [4:0] f, logic [NP-1:0] pv, logic chk);
    vec_t v;
    v.ser = ser; v.flags = f; v.pv = pv; v.chkSel = chk; v.sel = curSel;
    vecQ.push_back(v);
  endfunction

  function automatic void addIdle(int n);
    for (int i = 0; i < n; i++) pushVec(1'b1, 5'b0, '0, 1'b1);
  endfunction

  // Expected outputs seen after each bit is sampled, derived from the frame's bit positions.
  function automatic void addFrame(int addr, int data, bit badPar, bit badStop, int lows);
    logic fb[FL];
    logic par;
    logic good;
    logic [4:0] f;
    logic [NP-1:0] pv;
    par = 1'b0;
    fb[0] = 1'b0;
    for (int i = 0; i < A; i++) begin
      fb[1+i] = 1'((addr >> (A-1-i)) & 1);
      par ^= fb[1+i];
    end
    for (int i = 0; i < D; i++) begin
      fb[1+A+i] = 1'((data >> (D-1-i)) & 1);
      par ^= fb[1+A+i];
    end
    if (P == 1) fb[A+D+1] = par ^ badPar;
    fb[FL-1] = !badStop;
    good = !badStop && !(P == 1 && badPar);
    for (int i = 0; i < FL; i++) begin
      pv = '0;
      if (i >= A) curSel = A'(addr);
      if (i < FL-1) begin
        f = {1'(i < A), 1'(i >= A && i < A+D), 1'b1, 1'b0, 1'b0};
      end else if (good) begin
        f  = 5'b00010;
        pv = NP'(1) << addr;
      end else begin
        f = {2'b00, 1'(badStop), 1'b0, 1'b1};
      end
      pushVec(fb[i], f, pv, !(i >= 1 && i <= A-1));
    end
    if (badStop) begin
      for (int j = 0; j < lows; j++) pushVec(1'b0, 5'b00100, '0, 1'b1);
      pushVec(1'b1, 5'b0, '0, 1'b1);
    end
  endfunction

  task automatic applyVecs();
    foreach (vecQ[k]) begin
      bus.ser_in = vecQ[k].ser;
      @(negedge clk);
      #1;
      cyc++;
      checks++;
      if (gotFlags() !== vecQ[k].flags || bus.port_valid !== vecQ[k].pv) begin
        errors++;
        $display("FAIL outputs cycle %0d: got flags=%b port_valid=%b, required flags=%b port_valid=%b",
                 cyc, gotFlags(), bus.port_valid, vecQ[k].flags, vecQ[k].pv);
      end
      if (vecQ[k].chkSel) begin
        checks++;
        if (bus.port_sel !== vecQ[k].sel) begin
          errors++;
          $display("FAIL port_sel cycle %0d: got %0d, required %0d", cyc, bus.port_sel, vecQ[k].sel);
        end
      end
      if (vecQ[k].flags[1] || vecQ[k].flags[0])
        $display("cycle %0d: frame end done=%0b frame_err=%0b port_valid=%b port_sel=%0d",
                 cyc, bus.done, bus.frame_err, bus.port_valid, bus.port_sel);
    end
    vecQ.delete();
  endtask

  task automatic checkZero(string name);
    checks++;
    if (gotFlags() !== 5'b0 || bus.port_valid !== '0 || bus.port_sel !== '0) begin
      errors++;
      $display("FAIL %s: got flags=%b port_valid=%b port_sel=%0d, required all 0",
               name, gotFlags(), bus.port_valid, bus.port_sel);
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not complete, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic midBits[8];
    bus.ser_in = 1'b1;
    curSel = '0;
    #12;
    checkZero("reset_state");
    @(posedge clk);
    rst = 1'b1;

    addIdle(50);                          // idle line
    addFrame(2, 'hA5, 0, 0, 0);           // good frame to port 2
    addIdle(2);
    addFrame(1, 'h5A, 0, 1, 4);           // bad stop held low, then resync
    addFrame(2, 'hA5, 0, 0, 0);           // accepted right after resync
    addIdle(1);
    addFrame(3, 'h3C, 0, 0, 0);           // back-to-back pair
    addFrame(0, 'h81, 0, 0, 0);
    addIdle(2);
`ifdef SERIAL_RX_PARITY_EN
    addFrame(2, 'hA5, 1, 0, 0);           // wrong parity bit
    addIdle(2);
`endif
    for (int n = 0; n < 40; n++) begin
      addIdle(int'($urandom_range(0, 3)));
      addFrame(int'($urandom_range(0, NP-1)), int'($urandom_range(0, (1 << D) - 1)),
               (P == 1) && ($urandom_range(0, 5) == 0), $urandom_range(0, 5) == 0,
               int'($urandom_range(0, 3)));
    end
    addIdle(3);
    applyVecs();

    // Reset during DATA bit 4 of a frame to port 3.
    midBits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      bus.ser_in = midBits[i];
      @(negedge clk);
      #1;
    end
    checks++;
    if (!(bus.busy === 1'b1 && bus.data_sh_en === 1'b1 && bus.port_sel === 2'd3)) begin
      errors++;
      $display("FAIL mid_frame: got busy=%b data_sh_en=%b port_sel=%0d, required 1 1 3",
               bus.busy, bus.data_sh_en, bus.port_sel);
    end
    #2 rst = 1'b0;
    #1 checkZero("async_reset");
    @(negedge clk);
    #1 checkZero("reset_hold");
    @(posedge clk);
    bus.ser_in = 1'b1;
    rst = 1'b1;
    curSel = '0;
    addIdle(5);
    addFrame(3, 'h96, 0, 0, 0);
    addIdle(2);
    applyVecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
